// File: rtl/axis_demux_pkg.sv
// Shared types and constants for the AXI-Stream tdest demultiplexer.
// Optional drop counter: AXIS_DEST_DEMUX_DROP_CNT_EN (see axis_dest_demux.sv).
package axis_demux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam int DROP_CNT_WIDTH = 16;
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_CNT_MAX = '1;

endpackage

// File: rtl/axis_demux_out_reg.sv
// Single-output register slice: loads on a routed slave transfer, holds until drained.
module axis_demux_out_reg #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = 1,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 3,
    parameter int USER_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic [KEEP_WIDTH-1:0] s_tkeep,
    input  logic                  s_tlast,
    input  logic [ID_WIDTH-1:0]   s_tid,
    input  logic [DEST_WIDTH-1:0] s_tdest,
    input  logic [USER_WIDTH-1:0] s_tuser,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic [KEEP_WIDTH-1:0] m_tkeep,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [ID_WIDTH-1:0]   m_tid,
    output logic [DEST_WIDTH-1:0] m_tdest,
    output logic [USER_WIDTH-1:0] m_tuser
);

    // A load wins over a drain, so a beat arriving while the old one leaves keeps valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
            m_tid    <= '0;
            m_tdest  <= '0;
            m_tuser  <= '0;
        end else if (load) begin
            m_tvalid <= 1'b1;
            m_tdata  <= s_tdata;
            m_tkeep  <= s_tkeep;
            m_tlast  <= s_tlast;
            m_tid    <= s_tid;
            m_tdest  <= s_tdest;
            m_tuser  <= s_tuser;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_dest_demux.sv
// 1-to-M_COUNT AXI-Stream demux routing whole frames by the header beat's tdest.
// Define AXIS_DEST_DEMUX_DROP_CNT_EN to count discarded (out-of-range tdest) frames.
module axis_dest_demux
    import axis_demux_pkg::*;
#(
    parameter int M_COUNT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_WIDTH  = 3,
    parameter int USER_WIDTH  = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]            s_axis_tkeep,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    input  logic                             s_axis_tlast,
    input  logic [ID_WIDTH-1:0]              s_axis_tid,
    input  logic [DEST_WIDTH-1:0]            s_axis_tdest,
    input  logic [USER_WIDTH-1:0]            s_axis_tuser,
    output logic [M_COUNT*DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [M_COUNT*KEEP_WIDTH-1:0]    m_axis_tkeep,
    output logic [M_COUNT-1:0]               m_axis_tvalid,
    input  logic [M_COUNT-1:0]               m_axis_tready,
    output logic [M_COUNT-1:0]               m_axis_tlast,
    output logic [M_COUNT*ID_WIDTH-1:0]      m_axis_tid,
    output logic [M_COUNT*DEST_WIDTH-1:0]    m_axis_tdest,
    output logic [M_COUNT*USER_WIDTH-1:0]    m_axis_tuser,
    output logic [15:0]                      drop_count
);

    localparam int SEL_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;

    state_t             state, state_next;
    logic [SEL_W-1:0]   sel, sel_next, cur_sel;
    logic               dest_ok, cur_drop, xfer;
    logic [M_COUNT-1:0] load;

    // Extra MSB keeps the compare correct when M_COUNT == 2**DEST_WIDTH.
    assign dest_ok = ({1'b0, s_axis_tdest} < (DEST_WIDTH+1)'(M_COUNT));

    always_comb begin
        cur_sel    = sel;
        cur_drop   = 1'b0;
        state_next = state;
        sel_next   = sel;
        load       = '0;

        if (state == IDLE && M_COUNT > 1)
            cur_sel = s_axis_tdest[SEL_W-1:0];
        cur_drop = (state == DROP) || (state == IDLE && !dest_ok);

        if (rst)
            s_axis_tready = 1'b0;
        else if (cur_drop)
            s_axis_tready = 1'b1;
        else
            s_axis_tready = !m_axis_tvalid[cur_sel] || m_axis_tready[cur_sel];

        xfer = s_axis_tvalid && s_axis_tready;

        for (int i = 0; i < M_COUNT; i++)
            load[i] = xfer && !cur_drop && (cur_sel == SEL_W'(i));

        case (state)
            IDLE: begin
                if (xfer) begin
                    if (dest_ok)
                        sel_next = cur_sel;
                    if (!s_axis_tlast)
                        state_next = dest_ok ? PASS : DROP;
                end
            end
            PASS, DROP: begin
                if (xfer && s_axis_tlast)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
        end else begin
            state <= state_next;
            sel   <= sel_next;
        end
    end

`ifdef AXIS_DEST_DEMUX_DROP_CNT_EN
    logic [DROP_CNT_WIDTH-1:0] drop_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            drop_cnt <= '0;
        else if (xfer && s_axis_tlast && cur_drop && drop_cnt != DROP_CNT_MAX)
            drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
    end

    assign drop_count = drop_cnt;
`else
    assign drop_count = 16'h0000;
`endif

    for (genvar i = 0; i < M_COUNT; i++) begin : g_out
        logic [KEEP_WIDTH-1:0] keep_q;

        axis_demux_out_reg #(
            .DATA_WIDTH (DATA_WIDTH),
            .KEEP_WIDTH (KEEP_WIDTH),
            .ID_WIDTH   (ID_WIDTH),
            .DEST_WIDTH (DEST_WIDTH),
            .USER_WIDTH (USER_WIDTH)
        ) u_out (
            .clk      (clk),
            .rst      (rst),
            .load     (load[i]),
            .s_tdata  (s_axis_tdata),
            .s_tkeep  (s_axis_tkeep),
            .s_tlast  (s_axis_tlast),
            .s_tid    (s_axis_tid),
            .s_tdest  (s_axis_tdest),
            .s_tuser  (s_axis_tuser),
            .m_tdata  (m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH]),
            .m_tkeep  (keep_q),
            .m_tvalid (m_axis_tvalid[i]),
            .m_tready (m_axis_tready[i]),
            .m_tlast  (m_axis_tlast[i]),
            .m_tid    (m_axis_tid[i*ID_WIDTH +: ID_WIDTH]),
            .m_tdest  (m_axis_tdest[i*DEST_WIDTH +: DEST_WIDTH]),
            .m_tuser  (m_axis_tuser[i*USER_WIDTH +: USER_WIDTH])
        );

        assign m_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH] = (KEEP_ENABLE != 0) ? keep_q : '1;
    end

endmodule

// File: tb/tb_axis_dest_demux.sv
// Self-checking bench for axis_dest_demux: vector table plus per-output scoreboard queues.
module tb_axis_dest_demux;

    localparam int M   = 4;
    localparam int DW  = 8;
    localparam int KW  = 1;
    localparam int IW  = 8;
    localparam int DSW = 3;
    localparam int UW  = 1;

`ifdef AXIS_DEST_DEMUX_DROP_CNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   s_axis_tdata;
    logic [KW-1:0]   s_axis_tkeep;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic            s_axis_tlast;
    logic [IW-1:0]   s_axis_tid;
    logic [DSW-1:0]  s_axis_tdest;
    logic [UW-1:0]   s_axis_tuser;
    logic [M*DW-1:0] m_axis_tdata;
    logic [M*KW-1:0] m_axis_tkeep;
    logic [M-1:0]    m_axis_tvalid;
    logic [M-1:0]    m_axis_tready;
    logic [M-1:0]    m_axis_tlast;
    logic [M*IW-1:0] m_axis_tid;
    logic [M*DSW-1:0] m_axis_tdest;
    logic [M*UW-1:0] m_axis_tuser;
    logic [15:0]     drop_count;

    axis_dest_demux #(
        .M_COUNT(M), .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
        .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid),
        .s_axis_tdest(s_axis_tdest), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
        .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [7:0] id;
        logic [2:0] dest;
        logic       user;
        int         cyc;
        bit         lat;
    } exp_t;

    typedef struct {
        int         route;
        logic [2:0] dest;
        logic [7:0] data;
        logic       last;
    } vec_t;

    exp_t q [M][$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_wait = 0;
    logic [7:0] id_ctr = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: pop on every output handshake, flag valids nobody expected.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int i = 0; i < M; i++) begin
                if (m_axis_tvalid[i]) begin
                    if (q[i].size() == 0) begin
                        checks++; errors++;
                        $display("FAIL stray_valid out%0d data=%h (no beat expected)",
                                 i, m_axis_tdata[i*DW +: DW]);
                    end else if (m_axis_tready[i]) begin
                        e = q[i].pop_front();
                        checks++;
                        if ({m_axis_tdata[i*DW +: DW], m_axis_tlast[i], m_axis_tid[i*IW +: IW],
                             m_axis_tdest[i*DSW +: DSW], m_axis_tuser[i*UW +: UW],
                             m_axis_tkeep[i*KW +: KW]} !== {e.data, e.last, e.id, e.dest, e.user, 1'b1}) begin
                            errors++;
                            $display("FAIL beat out%0d got data=%h last=%b id=%h dest=%0d user=%b keep=%b exp data=%h last=%b id=%h dest=%0d user=%b keep=1",
                                     i, m_axis_tdata[i*DW +: DW], m_axis_tlast[i], m_axis_tid[i*IW +: IW],
                                     m_axis_tdest[i*DSW +: DSW], m_axis_tuser[i*UW +: UW],
                                     m_axis_tkeep[i*KW +: KW], e.data, e.last, e.id, e.dest, e.user);
                        end
                        if (e.lat) begin
                            checks++;
                            if (cyc != e.cyc) begin
                                errors++;
                                $display("FAIL latency out%0d data=%h got cycle %0d exp cycle %0d",
                                         i, e.data, cyc, e.cyc);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Presents one beat from posedge+1 and returns at posedge+1 after it transfers.
    task automatic send_beat(input int route, input logic [2:0] dest, input logic [7:0] data,
                             input logic last, input bit lat);
        int w;
        exp_t e;
        s_axis_tdata  = data;
        s_axis_tkeep  = 1'b1;
        s_axis_tdest  = dest;
        s_axis_tlast  = last;
        s_axis_tid    = id_ctr;
        s_axis_tuser  = data[0];
        s_axis_tvalid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!s_axis_tready && w < 50) begin
            w++;
            @(negedge clk);
        end
        if (w >= 50) begin
            checks++; errors++;
            $display("FAIL send_timeout data=%h dest=%0d waited %0d cycles", data, dest, w);
        end else if (route >= 0) begin
            e.data = data; e.last = last; e.id = id_ctr; e.dest = dest;
            e.user = data[0]; e.cyc = cyc + 1; e.lat = lat;
            q[route].push_back(e);
        end
        last_wait = w;
        id_ctr = id_ctr + 8'h01;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[$];
        int   t0;

        rst = 1'b1;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
        s_axis_tid = '0; s_axis_tdest = '0; s_axis_tuser = '0;
        m_axis_tready = '1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tready", 32'(s_axis_tready), 32'h0);
        check("reset_tvalid", 32'(m_axis_tvalid), 32'h0);
        check("reset_drop_count", 32'(drop_count), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single-beat frames, a 3-beat frame with changing tdest, then back-to-back alternation.
        vecs.push_back('{0, 3'd0, 8'h34, 1'b1});
        vecs.push_back('{1, 3'd1, 8'h12, 1'b1});
        vecs.push_back('{2, 3'd2, 8'hCD, 1'b1});
        vecs.push_back('{3, 3'd3, 8'hAB, 1'b1});
        vecs.push_back('{2, 3'd2, 8'hA0, 1'b0});
        vecs.push_back('{2, 3'd0, 8'hA1, 1'b0});
        vecs.push_back('{2, 3'd0, 8'hA2, 1'b1});
        for (int k = 0; k < 6; k++)
            vecs.push_back('{k % 2, 3'(k % 2), 8'(8'h50 + k), 1'b1});

        t0 = cyc;
        for (int k = 0; k < vecs.size(); k++)
            send_beat(vecs[k].route, vecs[k].dest, vecs[k].data, vecs[k].last, 1'b1);
        check("throughput_cycles", 32'(cyc - t0), 32'(vecs.size()));
        idle(3);

        // Backpressure on out1 for four cycles.
        m_axis_tready[1] = 1'b0;
        fork
            begin
                repeat (4) @(posedge clk);
                #1 m_axis_tready[1] = 1'b1;
            end
        join_none
        send_beat(1, 3'd1, 8'hB0, 1'b0, 1'b0);
        @(negedge clk);
        check("stall_tready", 32'(s_axis_tready), 32'h0);
        @(posedge clk); #1;
        send_beat(1, 3'd1, 8'hB1, 1'b0, 1'b0);
        send_beat(1, 3'd1, 8'hB2, 1'b1, 1'b0);
        idle(4);

        // Reset mid-frame to out3 while its beat is still held.
        m_axis_tready[3] = 1'b0;
        send_beat(3, 3'd3, 8'hC0, 1'b0, 1'b0);
        s_axis_tvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_tready", 32'(s_axis_tready), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        q[3].delete();
        @(negedge clk);
        check("rst_flush_tvalid", 32'(m_axis_tvalid), 32'h0);
        @(posedge clk); #1;
        m_axis_tready[3] = 1'b1;
        send_beat(1, 3'd1, 8'hC1, 1'b1, 1'b1);
        idle(2);

        // Out-of-range destinations are consumed without stalling.
        send_beat(-1, 3'd5, 8'hD0, 1'b0, 1'b0);
        check("drop_hdr_wait", 32'(last_wait), 32'h0);
        send_beat(-1, 3'd0, 8'hD1, 1'b1, 1'b0);
        check("drop_body_wait", 32'(last_wait), 32'h0);
        idle(1);
        @(negedge clk);
        check("drop_count_1", 32'(drop_count), 32'(CNT_EN));
        @(posedge clk); #1;
        send_beat(-1, 3'd7, 8'hD2, 1'b1, 1'b0);
        check("drop_single_wait", 32'(last_wait), 32'h0);
        idle(1);
        @(negedge clk);
        check("drop_count_2", 32'(drop_count), 32'(2 * CNT_EN));
        @(posedge clk); #1;
        send_beat(0, 3'd0, 8'hE0, 1'b1, 1'b1);
        idle(4);

        for (int i = 0; i < M; i++)
            check($sformatf("drain_out%0d", i), 32'(q[i].size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
